// File: rtl/mm2s_frame_checker_pkg.sv
// Shared definitions for the mm2s frame checker: FSM states, err_flags bit
// positions and CRC-16-CCITT constants.
package mm2s_frame_checker_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF  = 2'd0,
        IN_FRAME  = 2'd1,
        FRAME_END = 2'd2
    } state_t;

    localparam int ERR_SOF_MID   = 0;
    localparam int ERR_EOL_EARLY = 1;
    localparam int ERR_EOL_LATE  = 2;
    localparam int ERR_HEIGHT    = 3;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/mm2s_crc16.sv
// Running CRC-16-CCITT over every counted beat of a frame, MSB first; the
// frame result is captured when the checker signals frame completion.
module mm2s_crc16
    import mm2s_frame_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  beat,
    input  logic                  start,
    input  logic                  latch,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [15:0]           frame_crc
);

    logic [15:0] crc_run;
    logic [15:0] crc_next;

    // The first beat of a frame restarts from the init value instead of the running CRC.
    always_comb begin
        crc_next = start ? CRC_INIT : crc_run;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            crc_next = {crc_next[14:0], 1'b0} ^ ((crc_next[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            crc_run   <= 16'h0000;
            frame_crc <= 16'h0000;
        end else begin
            if (beat) crc_run <= crc_next;
            if (latch) frame_crc <= crc_run;
        end
    end

endmodule

// File: rtl/mm2s_frame_checker.sv
// AXI-Stream mm2s video frame checker with programmable tready backpressure.
// Optional frame CRC output when MM2S_FRAME_CRC_EN is defined.
//
// state     | meaning
// WAIT_SOF  | discard beats until one carries tuser
// IN_FRAME  | counting pixels/lines, flagging framing errors
// FRAME_END | final line accepted; pulse frame_done, bump frame_count
module mm2s_frame_checker
    import mm2s_frame_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  s_axis_mm2s_tvalid,
    output logic                  s_axis_mm2s_tready,
    input  logic                  s_axis_mm2s_tuser,
    input  logic                  s_axis_mm2s_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_mm2s_tdata,
    input  logic                  bp_en,
    input  logic [7:0]            bp_pattern,
    input  logic                  clear,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic [15:0]           x_count,
    output logic [15:0]           y_count,
`ifdef MM2S_FRAME_CRC_EN
    output logic [15:0]           frame_crc,
`endif
    output logic [3:0]            err_flags
);

    localparam logic [15:0] WIDTH  = 16'(IMG_WIDTH);
    localparam logic [15:0] HEIGHT = 16'(IMG_HEIGHT);
    localparam logic [15:0] LAST_Y = 16'(IMG_HEIGHT - 1);

    state_t      state, state_nxt;
    logic        run;
    logic        bp_en_q;
    logic [7:0]  bp_reg;
    logic        beat;
    logic        sof_beat;
    logic [15:0] x_inc, y_inc;
    logic [15:0] x_nxt, y_nxt, cnt_nxt;
    logic [3:0]  err_nxt;

    // run keeps tready low until the first clock edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run     <= 1'b0;
            bp_en_q <= 1'b0;
            bp_reg  <= 8'h00;
        end else begin
            run     <= 1'b1;
            bp_en_q <= bp_en;
            if (bp_en && !bp_en_q) bp_reg <= bp_pattern;
            else                   bp_reg <= {bp_reg[0], bp_reg[7:1]};
        end
    end

    assign s_axis_mm2s_tready = run && (!bp_en || bp_reg[0]);
    assign beat  = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
    assign x_inc = (x_count == 16'hFFFF) ? x_count : x_count + 16'd1;
    assign y_inc = (y_count == 16'hFFFF) ? y_count : y_count + 16'd1;

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_count;
        y_nxt      = y_count;
        cnt_nxt    = frame_count;
        err_nxt    = err_flags;
        frame_done = 1'b0;
        sof_beat   = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (beat && s_axis_mm2s_tuser) begin
                    state_nxt = IN_FRAME;
                    x_nxt     = 16'd1;
                    y_nxt     = 16'd0;
                    sof_beat  = 1'b1;
                end
            end
            IN_FRAME: begin
                if (beat) begin
                    if (s_axis_mm2s_tuser) begin
                        err_nxt[ERR_SOF_MID] = 1'b1;
                        if (y_count != HEIGHT) err_nxt[ERR_HEIGHT] = 1'b1;
                        x_nxt    = 16'd1;
                        y_nxt    = 16'd0;
                        sof_beat = 1'b1;
                    end else if (s_axis_mm2s_tlast) begin
                        if (x_inc < WIDTH) err_nxt[ERR_EOL_EARLY] = 1'b1;
                        x_nxt = 16'd0;
                        if (y_count == LAST_Y) begin
                            state_nxt = FRAME_END;
                            y_nxt     = 16'd0;
                        end else begin
                            y_nxt = y_inc;
                        end
                    end else begin
                        if (x_inc == WIDTH) err_nxt[ERR_EOL_LATE] = 1'b1;
                        x_nxt = x_inc;
                    end
                end
            end
            FRAME_END: begin
                frame_done = 1'b1;
                cnt_nxt    = frame_count + 16'd1;
                state_nxt  = WAIT_SOF;
                // A back-to-back start of frame is accepted while the pulse is out.
                if (beat && s_axis_mm2s_tuser) begin
                    state_nxt = IN_FRAME;
                    x_nxt     = 16'd1;
                    y_nxt     = 16'd0;
                    sof_beat  = 1'b1;
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
        if (clear) begin
            state_nxt = WAIT_SOF;
            x_nxt     = 16'd0;
            y_nxt     = 16'd0;
            cnt_nxt   = 16'd0;
            err_nxt   = 4'h0;
            sof_beat  = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= WAIT_SOF;
            x_count     <= 16'd0;
            y_count     <= 16'd0;
            frame_count <= 16'd0;
            err_flags   <= 4'h0;
        end else begin
            state       <= state_nxt;
            x_count     <= x_nxt;
            y_count     <= y_nxt;
            frame_count <= cnt_nxt;
            err_flags   <= err_nxt;
        end
    end

`ifdef MM2S_FRAME_CRC_EN
    logic crc_beat;
    assign crc_beat = sof_beat || (beat && state == IN_FRAME && !clear);

    mm2s_crc16 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_crc (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .beat      (crc_beat),
        .start     (sof_beat),
        .latch     (frame_done),
        .data      (s_axis_mm2s_tdata),
        .frame_crc (frame_crc)
    );
`else
    logic data_unused;
    assign data_unused = ^{s_axis_mm2s_tdata, sof_beat};
`endif

endmodule

// File: tb/tb_mm2s_frame_checker.sv
// Scenario bench for mm2s_frame_checker at a 4x3 image; expected frame
// completions are queued as beats are driven and checked as frame_done fires.
module tb_mm2s_frame_checker;

    localparam int W = 4;
    localparam int H = 3;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        s_axis_mm2s_tvalid = 1'b0;
    logic        s_axis_mm2s_tready;
    logic        s_axis_mm2s_tuser = 1'b0;
    logic        s_axis_mm2s_tlast = 1'b0;
    logic [15:0] s_axis_mm2s_tdata = 16'h0000;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_pattern = 8'h00;
    logic        clear = 1'b0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] x_count;
    logic [15:0] y_count;
    logic [3:0]  err_flags;
`ifdef MM2S_FRAME_CRC_EN
    logic [15:0] frame_crc;
`endif

    typedef struct {
        logic [15:0] cnt;
        logic [3:0]  err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_crc = 16'h0000;

    mm2s_frame_checker #(
        .DATA_WIDTH(16),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .ACLK               (ACLK),
        .ARESETN            (ARESETN),
        .s_axis_mm2s_tvalid (s_axis_mm2s_tvalid),
        .s_axis_mm2s_tready (s_axis_mm2s_tready),
        .s_axis_mm2s_tuser  (s_axis_mm2s_tuser),
        .s_axis_mm2s_tlast  (s_axis_mm2s_tlast),
        .s_axis_mm2s_tdata  (s_axis_mm2s_tdata),
        .bp_en              (bp_en),
        .bp_pattern         (bp_pattern),
        .clear              (clear),
        .frame_done         (frame_done),
        .frame_count        (frame_count),
        .x_count            (x_count),
        .y_count            (y_count),
`ifdef MM2S_FRAME_CRC_EN
        .frame_crc          (frame_crc),
`endif
        .err_flags          (err_flags)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // One beat: hold it until accepted, then settle the scoreboard for that edge.
    task automatic drive_beat(input logic u, input logic l, input logic [15:0] d);
        int   n;
        exp_t e;
        s_axis_mm2s_tvalid = 1'b1;
        s_axis_mm2s_tuser  = u;
        s_axis_mm2s_tlast  = l;
        s_axis_mm2s_tdata  = d;
        n = 0;
        while (s_axis_mm2s_tready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: tready=%b required 1", s_axis_mm2s_tready);
            s_axis_mm2s_tvalid = 1'b0;
            if (sb.size() > 0) e = sb.pop_front();
        end else begin
            step();
            s_axis_mm2s_tvalid = 1'b0;
            s_axis_mm2s_tuser  = 1'b0;
            s_axis_mm2s_tlast  = 1'b0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_latency: frame_done=%b required 1", frame_done);
                end
                checks++;
                if (frame_count !== e.cnt) begin
                    errors++;
                    $display("FAIL done_count: frame_count=%0d required %0d", frame_count, e.cnt);
                end
                checks++;
                if (err_flags !== e.err) begin
                    errors++;
                    $display("FAIL done_err: err_flags=%b required %b", err_flags, e.err);
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_done: frame_done=%b required 0", frame_done);
                end
            end
        end
    endtask

    task automatic send_frame(input int l0, input int l1, input int l2,
                              input logic [15:0] cnt_before, input logic [3:0] err, input bit zero);
        int          lens[3];
        int          k;
        logic [15:0] c;
        logic [15:0] d;
        logic        last;
        exp_t        e;
        lens[0] = l0;
        lens[1] = l1;
        lens[2] = l2;
        k = 0;
        c = 16'hFFFF;
        for (int li = 0; li < 3; li++) begin
            for (int b = 0; b < lens[li]; b++) begin
                last = (b == lens[li] - 1);
                d = zero ? 16'h0000 : 16'(k * 37 + 5);
                c = crc_step(c, d);
                if (li == 2 && last) begin
                    e.cnt = cnt_before;
                    e.err = err;
                    sb.push_back(e);
                end
                drive_beat(k == 0, last, d);
                k++;
            end
        end
        model_crc = c;
    endtask

    task automatic check_after(input string name, input logic [15:0] cnt, input logic [3:0] err);
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: frame_done=%b required 0", name, frame_done);
        end
        checks++;
        if (frame_count !== cnt) begin
            errors++;
            $display("FAIL %s_count: frame_count=%0d required %0d", name, frame_count, cnt);
        end
        checks++;
        if (err_flags !== err) begin
            errors++;
            $display("FAIL %s_err: err_flags=%b required %b", name, err_flags, err);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({s_axis_mm2s_tready, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_done: got %b required 00", {s_axis_mm2s_tready, frame_done});
        end
        checks++;
        if ({frame_count, x_count, y_count, err_flags} !== 52'h0) begin
            errors++;
            $display("FAIL reset_counters: cnt=%0d x=%0d y=%0d err=%b required all 0",
                     frame_count, x_count, y_count, err_flags);
        end
`ifdef MM2S_FRAME_CRC_EN
        checks++;
        if (frame_crc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_crc: frame_crc=%h required 0000", frame_crc);
        end
`endif
        ARESETN = 1'b1;
        #2;
        checks++;
        if (s_axis_mm2s_tready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: tready=%b required 0", s_axis_mm2s_tready);
        end
        step();
        checks++;
        if (s_axis_mm2s_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: tready=%b required 1", s_axis_mm2s_tready);
        end
    endtask

    task automatic test_clean_frame();
        send_frame(4, 4, 4, 16'd0, 4'b0000, 1'b0);
        check_after("clean", 16'd1, 4'b0000);
    endtask

    task automatic test_backpressure();
        logic t0;
        do_clear();
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_count: frame_count=%0d required 0", frame_count);
        end
        bp_pattern = 8'b1010_1010;
        bp_en = 1'b1;
        step();
        step();
        t0 = s_axis_mm2s_tready;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (s_axis_mm2s_tready !== (t0 ^ 1'(i & 1))) begin
                errors++;
                $display("FAIL bp_toggle: tready=%b required %b", s_axis_mm2s_tready, t0 ^ 1'(i & 1));
            end
        end
        send_frame(4, 4, 4, 16'd0, 4'b0000, 1'b0);
        check_after("bp", 16'd1, 4'b0000);
        bp_en = 1'b0;
        step();
    endtask

    task automatic test_eol_early();
        do_clear();
        send_frame(3, 4, 4, 16'd0, 4'b0010, 1'b0);
        check_after("eol_early", 16'd1, 4'b0010);
        checks++;
        if (y_count !== 16'd0) begin
            errors++;
            $display("FAIL eol_early_y: y_count=%0d required 0", y_count);
        end
    endtask

    task automatic test_eol_late();
        exp_t e;
        do_clear();
        for (int b = 0; b < 4; b++) drive_beat(b == 0, 1'b0, 16'(b));
        checks++;
        if (x_count !== 16'd4 || err_flags !== 4'b0100) begin
            errors++;
            $display("FAIL eol_late_flag: x=%0d err=%b required x=4 err=0100", x_count, err_flags);
        end
        drive_beat(1'b0, 1'b1, 16'h0004);
        checks++;
        if (x_count !== 16'd0 || y_count !== 16'd1) begin
            errors++;
            $display("FAIL eol_late_wrap: x=%0d y=%0d required x=0 y=1", x_count, y_count);
        end
        for (int li = 1; li < 3; li++) begin
            for (int b = 0; b < 4; b++) begin
                if (li == 2 && b == 3) begin
                    e.cnt = 16'd0;
                    e.err = 4'b0100;
                    sb.push_back(e);
                end
                drive_beat(1'b0, b == 3, 16'(li * 4 + b));
            end
        end
        check_after("eol_late", 16'd1, 4'b0100);
    endtask

    task automatic test_sof_mid();
        do_clear();
        for (int b = 0; b < 4; b++) drive_beat(b == 0, b == 3, 16'(b));
        drive_beat(1'b0, 1'b0, 16'h0010);
        drive_beat(1'b1, 1'b0, 16'h0011);
        checks++;
        if (err_flags !== 4'b1001 || x_count !== 16'd1 || y_count !== 16'd0) begin
            errors++;
            $display("FAIL sof_mid: err=%b x=%0d y=%0d required err=1001 x=1 y=0",
                     err_flags, x_count, y_count);
        end
        send_frame(4, 4, 4, 16'd0, 4'b1001, 1'b0);
        check_after("sof_mid", 16'd1, 4'b1001);
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 6; b++) drive_beat(b == 0, b == 3, 16'(b));
        ARESETN = 1'b0;
        #2;
        checks++;
        if ({s_axis_mm2s_tready, frame_done} !== 2'b00 ||
            {frame_count, x_count, y_count, err_flags} !== 52'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b done=%b cnt=%0d x=%0d y=%0d err=%b required all 0",
                     s_axis_mm2s_tready, frame_done, frame_count, x_count, y_count, err_flags);
        end
        step();
        step();
        ARESETN = 1'b1;
        step();
        drive_beat(1'b0, 1'b0, 16'h0020);
        drive_beat(1'b0, 1'b1, 16'h0021);
        checks++;
        if (x_count !== 16'd0 || y_count !== 16'd0) begin
            errors++;
            $display("FAIL discard_wait_sof: x=%0d y=%0d required 0 0", x_count, y_count);
        end
        send_frame(4, 4, 4, 16'd0, 4'b0000, 1'b0);
        check_after("reset_mid", 16'd1, 4'b0000);
    endtask

    task automatic test_back_to_back();
        send_frame(4, 4, 4, 16'd1, 4'b0000, 1'b0);
        send_frame(4, 4, 4, 16'd2, 4'b0000, 1'b0);
        check_after("b2b", 16'd3, 4'b0000);
    endtask

    task automatic test_clear_priority();
        drive_beat(1'b1, 1'b0, 16'h0030);
        drive_beat(1'b0, 1'b0, 16'h0031);
        s_axis_mm2s_tvalid = 1'b1;
        s_axis_mm2s_tuser  = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        s_axis_mm2s_tvalid = 1'b0;
        s_axis_mm2s_tuser  = 1'b0;
        checks++;
        if ({frame_count, x_count, y_count, err_flags} !== 52'h0) begin
            errors++;
            $display("FAIL clear_priority: cnt=%0d x=%0d y=%0d err=%b required all 0",
                     frame_count, x_count, y_count, err_flags);
        end
        drive_beat(1'b0, 1'b0, 16'h0032);
        checks++;
        if (x_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_to_wait_sof: x=%0d required 0", x_count);
        end
    endtask

`ifdef MM2S_FRAME_CRC_EN
    task automatic test_crc();
        logic [15:0] ref_crc;
        do_clear();
        ref_crc = 16'hFFFF;
        for (int i = 0; i < 12; i++) ref_crc = crc_step(ref_crc, 16'h0000);
        send_frame(4, 4, 4, 16'd0, 4'b0000, 1'b1);
        step();
        checks++;
        if (frame_crc !== ref_crc) begin
            errors++;
            $display("FAIL crc_value: frame_crc=%h required %h", frame_crc, ref_crc);
        end
        for (int b = 0; b < 3; b++) drive_beat(b == 0, 1'b0, 16'h1234);
        checks++;
        if (frame_crc !== ref_crc) begin
            errors++;
            $display("FAIL crc_hold: frame_crc=%h required %h", frame_crc, ref_crc);
        end
        do_clear();
        send_frame(4, 4, 4, 16'd0, 4'b0000, 1'b0);
        step();
        checks++;
        if (frame_crc !== model_crc) begin
            errors++;
            $display("FAIL crc_data: frame_crc=%h required %h", frame_crc, model_crc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_eol_early();
        test_eol_late();
        test_sof_mid();
        test_reset_mid();
        test_back_to_back();
        test_clear_priority();
`ifdef MM2S_FRAME_CRC_EN
        test_crc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm2s_frame_checker.md
MM2S_FRAME_CHECKER -- requirements
Module: mm2s_frame_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of s_axis_mm2s_tdata.
REQ-002 Parameter IMG_WIDTH, default 1920: expected pixels (beats) per line.
REQ-003 Parameter IMG_HEIGHT, default 1080: expected lines per frame.
REQ-004 Port ACLK, input, 1: sole clock; all logic on its rising edge.
REQ-005 Port ARESETN, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port s_axis_mm2s_tvalid, input, 1: beat valid from the video-processing mm2s master.
REQ-007 Port s_axis_mm2s_tready, output, 1: checker accepts the beat.
REQ-008 Port s_axis_mm2s_tuser, input, 1: start-of-frame marker on the first beat.
REQ-009 Port s_axis_mm2s_tlast, input, 1: end-of-line marker.
REQ-010 Port s_axis_mm2s_tdata, input, DATA_WIDTH: pixel data.
REQ-011 Port bp_en, input, 1: enables the backpressure pattern.
REQ-012 Port bp_pattern, input, 8: tready mask, rotated one bit per cycle.
REQ-013 Port clear, input, 1: synchronous clear of counters and sticky errors.
REQ-014 Port frame_done, output, 1: one-cycle pulse on frame completion.
REQ-015 Port frame_count, output, 16: completed frames, wraps 0xFFFF->0.
REQ-016 Port x_count / y_count, output, 16 each: current pixel/line position.
REQ-017 Port err_flags, output, 4: sticky {err_height, err_eol_late, err_eol_early, err_sof_mid}.

Function
REQ-018 A beat is a transfer only when tvalid&&tready are both high on a rising ACLK edge.
REQ-019 With bp_en=0, tready is 1 whenever not in reset; with bp_en=1, tready = bit 0 of an 8-bit register loaded from bp_pattern on bp_en rise and rotated right every cycle.
REQ-020 FSM states: WAIT_SOF, IN_FRAME, FRAME_END.
REQ-021 WAIT_SOF: beats without tuser are discarded without counting; a tuser beat -> IN_FRAME, x_count=1, y_count=0.
REQ-022 IN_FRAME: each beat increments x_count; a tlast beat with x_count+1==IMG_WIDTH sets x_count=0 and increments y_count.
REQ-023 tlast with x_count+1<IMG_WIDTH sets err_eol_early and still ends the line.
REQ-024 Beat number IMG_WIDTH without tlast sets err_eol_late; x_count keeps counting until tlast.
REQ-025 tuser beat in IN_FRAME sets err_sof_mid, and sets err_height if y_count!=IMG_HEIGHT; restarts the frame at x=1, y=0 without pulsing frame_done.
REQ-026 Line-ending beat for line IMG_HEIGHT-1 -> FRAME_END; next cycle frame_done=1 for one cycle, frame_count increments, -> WAIT_SOF.
REQ-027 frame_done latency: exactly one cycle after the final tlast transfer.
REQ-028 clear: zeroes frame_count and err_flags, and returns the FSM to WAIT_SOF; clear has priority over a simultaneous beat.
REQ-029 Counters are 16 bits; they saturate at 0xFFFF except frame_count, which wraps.

Reset
REQ-030 ARESETN low: FSM=WAIT_SOF; tready=0; frame_done=0; frame_count, x_count, y_count and err_flags all 0; the bp register is 0.
REQ-031 Reset asserted mid-frame discards the partial frame; after release the checker waits for the next tuser.
REQ-032 tready rises no earlier than the first ACLK edge after ARESETN deasserts.

Configuration
REQ-033 Macro MM2S_FRAME_CRC_EN: when defined, adds output frame_crc[15:0], a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over tdata of all counted beats in a frame, updated each beat, latched on frame_done, and reset to 0.
REQ-034 Without MM2S_FRAME_CRC_EN, no CRC logic or port exists; all other behaviour is identical.

Structure
REQ-035 The shared package holds the FSM state enum, the err_flags bit-index constants, and the CRC polynomial/init constants.
REQ-036 The CRC is one sub-module, mm2s_crc16, instantiated only under MM2S_FRAME_CRC_EN.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3)
REQ-037 Clean frame of 12 beats with tuser on beat 0 and tlast on every 4th beat, bp_en=0 -> frame_done one cycle after beat 11, frame_count=1, err_flags=0.
REQ-038 Same frame with bp_en=1, bp_pattern=8'b1010_1010 -> tready toggles every cycle; same result, no beat lost or duplicated.
REQ-039 tlast on beat 2 of line 0 -> err_flags=4'b0010; frame still completes with y_count wrapping.
REQ-040 tuser at line 1, beat 1 -> err_flags=4'b1001, no frame_done; next clean frame -> frame_count=1.
REQ-041 ARESETN pulsed low mid-line 1 -> all outputs 0; next clean frame -> frame_count=1, err_flags=0.
REQ-042 With MM2S_FRAME_CRC_EN, 12 beats of tdata=0x0000 -> frame_crc equals the reference-model CRC and holds until the next frame_done.
